// File: rtl/adis_spi_responder.sv
// adis_spi_responder
// SPI mode-3 responder that emulates the ADIS16209 register interface, so the
// sensor-side SPI initiator and the UART packet path can be exercised in-system.
// All SPI pins are oversampled in the clk domain. clk must run at least 8x SCLK.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   sclk, cs_n      SPI clock (idle high) and chip select (active low) from the initiator
//   mosi, miso      serial data in and out, MSB first; miso is 0 while cs_n is high
//   sample_we/addr/data  user-side word writes into the sensor registers
//   frame_done      one-cycle pulse once a full 16-bit command has been decoded
//   frame_abort     one-cycle pulse when cs_n rises after 1-15 bits
//   cmd_word        last complete command; updates together with frame_done
module adis_spi_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        sample_we,
  input  logic [5:0]  sample_addr,
  input  logic [15:0] sample_data,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] cmd_word
);

  localparam logic [5:0]  PROD_ID_WORD = 6'd37;
  localparam logic [15:0] PROD_ID_VAL  = 16'h3F51;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t      state, state_n;
  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_d, cs_d;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0]  bit_cnt;
  logic [15:0] sh_in, sh_out, pend_word;
  logic        dec_pend;
  logic [15:0] regs [64];

  // CS_N synchronizer resets low: if reset lands mid-frame while CS_N is
  // still low, no false falling edge is seen afterwards, so the next frame
  // needs a real CS_N fall. A rising edge seen in IDLE is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b11;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise =  sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] &  sclk_d;
  assign cs_rise   =  cs_sync[1]   & ~cs_d;
  assign cs_fall   = ~cs_sync[1]   &  cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cs_fall) state_n = ACTIVE;
      ACTIVE:  if (cs_rise) state_n = IDLE;
               else if (sclk_rise && bit_cnt == 4'd15) state_n = HOLD;
      HOLD:    if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Decoded SPI write, valid in the cycle after the 16th bit lands.
  logic       spi_we, spi_hi;
  logic [5:0] spi_word;
  always_comb begin
    spi_word = sh_in[14:9];
    spi_hi   = sh_in[8];
    spi_we   = dec_pend & sh_in[15] & (spi_word != PROD_ID_WORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      sh_in       <= '0;
      sh_out      <= '0;
      miso        <= 1'b0;
      dec_pend    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      cmd_word    <= '0;
      pend_word   <= '0;
    end else begin
      dec_pend    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (state == IDLE && cs_fall) begin
        sh_out  <= pend_word;
        miso    <= pend_word[15];
        bit_cnt <= '0;
      end else if (state == ACTIVE && !cs_rise) begin
        if (sclk_rise) begin
          sh_in   <= {sh_in[14:0], mosi_sync[1]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) dec_pend <= 1'b1;
        end
        // Mode 3 opens with a falling edge before any bit is sampled; bit 15
        // is already on miso from the CS_N fall, so only shift after a rise.
        if (sclk_fall && bit_cnt != 4'd0) begin
          sh_out <= {sh_out[14:0], 1'b0};
          miso   <= sh_out[14];
        end
      end
      if (cs_rise) begin
        miso <= 1'b0;
        if (state == ACTIVE && bit_cnt != 4'd0) frame_abort <= 1'b1;
      end
      if (dec_pend) begin
        frame_done <= 1'b1;
        cmd_word   <= sh_in;
        pend_word  <= sh_in[15] ? 16'h0000 : regs[sh_in[14:9]];
      end
    end
  end

  // Sample write first, SPI byte write second: on a same-word collision the
  // SPI byte wins and the other byte comes from sample_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) regs[i] <= 16'h0000;
      regs[PROD_ID_WORD] <= PROD_ID_VAL;
    end else begin
      if (sample_we && sample_addr != PROD_ID_WORD) regs[sample_addr] <= sample_data;
      if (spi_we) begin
        if (spi_hi) regs[spi_word][15:8] <= sh_in[7:0];
        else        regs[spi_word][7:0]  <= sh_in[7:0];
      end
    end
  end

endmodule

// File: doc/adis_spi_responder.md
# adis_spi_responder

SPI responder that emulates the ADIS16209 register interface, so the sensor-facing SPI initiator and the packet path that inserts sensor words into UART frames can run and be verified against it in-system. It oversamples SCLK/CS_N/MOSI in the system clock domain, decodes 16-bit read/write commands, and returns the addressed register word during the following frame. A user-side sample port refreshes the sensor output registers.

## Interface
- No parameters; register bank fixed at 64 words x 16 bits (byte addresses 0x00-0x7F).
- `clk`  in  1  system clock (42 MHz domain); must be >= 8x SCLK frequency.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `sclk`  in  1  SPI clock from initiator, mode 3 (idle high, sample on rising, shift on falling).
- `cs_n`  in  1  SPI chip select, active low.
- `mosi`  in  1  serial data from initiator, MSB first.
- `miso`  out  1  serial data to initiator, MSB first; 0 while CS_N high.
- `sample_we`  in  1  write strobe for sample port.
- `sample_addr`  in  6  word address for sample port.
- `sample_data`  in  16  word written by sample port.
- `frame_done`  out  1  one-cycle pulse after a complete 16-bit frame is decoded.
- `frame_abort`  out  1  one-cycle pulse when CS_N rises with 1-15 bits received.
- `cmd_word`  out  16  last complete received command; updates with `frame_done`.

## Operation
- Inputs pass through 2-flop synchronizers; edges detected on synchronized SCLK and CS_N.
- States: IDLE (CS_N high) -> ACTIVE on CS_N fall -> HOLD after 16th rising SCLK -> IDLE on CS_N rise. ACTIVE -> IDLE on CS_N rise before 16 bits (abort).
- CS_N fall: load shift-out register with `pend_word`, bit count = 0, `miso` = bit 15.
- Rising SCLK in ACTIVE: shift in synchronized MOSI, count+1. Falling SCLK in ACTIVE: shift out next bit. SCLK edges in HOLD/IDLE ignored.
- Command decode (one cycle after 16th bit): bit15=1 write, bits[14:8] byte address, bits[7:0] data; bit15=0 read, bits[14:8] byte address, bits[7:0] ignored.
- Write: even address -> low byte of word addr[6:1]; odd -> high byte. Word 37 (byte 0x4A/0x4B, PROD_ID) read-only; writes dropped. `pend_word` <= 0x0000.
- Read: `pend_word` <= word addr[6:1] (byte address LSB ignored).
- Abort: no decode, no register change, `pend_word` unchanged, `frame_abort` pulses.
- Sample port: `sample_we` writes `sample_data` to word `sample_addr`; word 37 ignored. Same-cycle collision with SPI write to the same word: SPI byte write applied, other byte from `sample_data`.
- Reset values: all words 0x0000 except word 37 = 0x3F51; `pend_word`=0, state IDLE, `miso`=0, `frame_done`=0, `frame_abort`=0, `cmd_word`=0.
- Reset mid-frame: immediate return to IDLE; next frame starts only on a fresh CS_N fall.

## Timing
- `miso` update: 3 clk after falling SCLK/CS_N at pins (2 sync + 1 register).
- `frame_done`/`cmd_word`/register write: 4 clk after 16th rising SCLK at pins.
- `frame_abort`: 3 clk after CS_N rise at pins.
- Read data visible from the first bit of the very next frame; back-to-back frames need >= 4 clk of CS_N high.
- Sample-port write visible to a read decoded 1 clk later or after.

## Test plan
- After reset: frame 0x4A00 then 0x0000 -> second frame MISO = 0x3F51; `cmd_word` = 0x4A00 then 0x0000, two `frame_done` pulses.
- Frames 0x8A12, 0x8B34, 0x0A00, 0x0000 -> fourth frame MISO = 0x3412; third frame MISO = 0x0000 (after write).
- Write 0xCA55 (PROD_ID) then read 0x4A00 -> returns 0x3F51.
- CS_N high after 8 bits of 0x8C77 -> `frame_abort` pulse, no `frame_done`, read of 0x0C returns 0x0000.
- `sample_we`, addr 6, data 0xBEEF, same cycle as SPI write 0x8D01 decodes -> read 0x0C returns 0x01EF.
- Assert `rst` after 10 bits of a frame -> `miso`=0, IDLE; next full read 0x4A00/0x0000 returns 0x3F51.
